// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and MEM-side resolution signals shared by the predictor and the pipeline.
interface branch_predictor_if;
    logic [31:0] imemaddr_if;
    logic        branch_hit_if;
    logic [1:0]  branch_history_if;
    logic [31:0] target_address_if;
    logic [31:0] pc_predicted_if;
    logic        update_en;
    logic [31:0] imemaddr_mem;
    logic        branch_hit_mem;
    logic [1:0]  branch_history_mem;
    logic [31:0] target_address_mem;
    logic        taken_mem;
    logic [31:0] branch_target_mem;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport slave (
        input  imemaddr_if,
        output branch_hit_if, branch_history_if, target_address_if, pc_predicted_if,
        input  update_en, imemaddr_mem, branch_hit_mem, branch_history_mem,
        input  target_address_mem, taken_mem, branch_target_mem,
        output mispredict, branch_count, mispredict_count
    );

    modport master (
        output imemaddr_if,
        input  branch_hit_if, branch_history_if, target_address_if, pc_predicted_if,
        output update_en, imemaddr_mem, branch_hit_mem, branch_history_mem,
        output target_address_mem, taken_mem, branch_target_mem,
        input  mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// 8-entry direct-mapped BTB with 2-bit saturating counters; combinational lookup,
// MEM-stage update, and resolved/mispredicted branch counters.
module branch_predictor (
    input  logic               CLK,
    input  logic               nRST,
    branch_predictor_if.slave  bp
);
    localparam int unsigned ENTRIES = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned TAG_W   = 27;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } entry_t;

    entry_t            tbl_q [ENTRIES];
    entry_t            look_e;
    logic [IDX_W-1:0]  look_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              hit_c;
    logic              pred_mem_c;
    logic              mispredict_c;
    logic [CNT_W-1:0]  branch_count_q;
    logic [CNT_W-1:0]  mispredict_count_q;
    logic              unused_addr_bits;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken && c != 2'b11) n = c + 2'b01;
        else if (!taken && c != 2'b00) n = c - 2'b01;
        return n;
    endfunction

    assign look_idx = bp.imemaddr_if[4:2];
    assign upd_idx  = bp.imemaddr_mem[4:2];
    assign look_e   = tbl_q[look_idx];

    // Lookup reads stored state only, so a same-cycle update is not bypassed
    assign hit_c                = look_e.valid && (look_e.tag == bp.imemaddr_if[31:5]);
    assign bp.branch_hit_if     = hit_c;
    assign bp.branch_history_if = hit_c ? look_e.ctr : 2'b00;
    assign bp.target_address_if = hit_c ? look_e.target : ADDR_W'(0);
    assign bp.pc_predicted_if   = (hit_c && look_e.ctr[1]) ? look_e.target
                                                           : bp.imemaddr_if + ADDR_W'(4);

    assign pred_mem_c   = bp.branch_hit_mem && bp.branch_history_mem[1];
    assign mispredict_c = bp.update_en &&
                          ((pred_mem_c != bp.taken_mem) ||
                           (bp.taken_mem && (bp.target_address_mem != bp.branch_target_mem)));
    assign bp.mispredict = mispredict_c;

    assign unused_addr_bits = ^{bp.imemaddr_if[1:0], bp.imemaddr_mem[1:0]};

    // Table update: allocate on miss, train counter (and target if taken) on hit
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tbl_q <= '{default: '0};
        end else if (bp.update_en) begin
            if (!bp.branch_hit_mem) begin
                tbl_q[upd_idx].valid  <= 1'b1;
                tbl_q[upd_idx].tag    <= bp.imemaddr_mem[31:5];
                tbl_q[upd_idx].target <= bp.branch_target_mem;
                tbl_q[upd_idx].ctr    <= bp.taken_mem ? 2'b10 : 2'b01;
            end else begin
                tbl_q[upd_idx].ctr <= sat_ctr(bp.branch_history_mem, bp.taken_mem);
                if (bp.taken_mem) tbl_q[upd_idx].target <= bp.branch_target_mem;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (bp.update_en && branch_count_q != '1)
                branch_count_q <= branch_count_q + CNT_W'(1);
            if (mispredict_c && mispredict_count_q != '1)
                mispredict_count_q <= mispredict_count_q + CNT_W'(1);
        end
    end

    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; expectations queued per step, then popped and checked.
module tb_branch_predictor;
    logic clk;
    logic nrst;

    branch_predictor_if bp ();

    branch_predictor dut (
        .CLK  (clk),
        .nRST (nrst),
        .bp   (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic exp_look(input logic hit, input logic [1:0] hist,
                            input logic [31:0] tgt, input logic [31:0] pcp);
        push("hit", 32'(hit));
        push("hist", 32'(hist));
        push("target", tgt);
        push("pc_pred", pcp);
    endtask

    task automatic exp_cnt(input logic [31:0] bc, input logic [31:0] mc);
        push("branch_count", bc);
        push("mispredict_count", mc);
    endtask

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "hit":              return 32'(bp.branch_hit_if);
            "hist":             return 32'(bp.branch_history_if);
            "target":           return bp.target_address_if;
            "pc_pred":          return bp.pc_predicted_if;
            "mispredict":       return 32'(bp.mispredict);
            "branch_count":     return bp.branch_count;
            "mispredict_count": return bp.mispredict_count;
            default:            return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Drain the scoreboard against current DUT outputs
    task automatic check_all(input string step);
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.tag);
            checks++;
            assert (o === e.v)
            else begin
                errors++;
                $error("FAIL %s/%s observed=%h expected=%h", step, e.tag, o, e.v);
            end
        end
    endtask

    task automatic set_upd(input logic en, input logic [31:0] pc, input logic hitm,
                           input logic [1:0] histm, input logic [31:0] tgtm,
                           input logic taken, input logic [31:0] bt);
        bp.update_en          = en;
        bp.imemaddr_mem       = pc;
        bp.branch_hit_mem     = hitm;
        bp.branch_history_mem = histm;
        bp.target_address_mem = tgtm;
        bp.taken_mem          = taken;
        bp.branch_target_mem  = bt;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        nrst = 1'b0;
        bp.imemaddr_if = 32'h40;
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);

        // In reset
        #1;
        exp_look(1'b0, 2'b00, 32'h0, 32'h44);
        exp_cnt(32'd0, 32'd0);
        check_all("in_reset");

        next_cycle();
        nrst = 1'b1;
        next_cycle();
        #1;
        exp_look(1'b0, 2'b00, 32'h0, 32'h44);
        check_all("cold_lookup");

        // Allocate 0x40 taken -> 0x100; same-cycle lookup still misses
        set_upd(1'b1, 32'h40, 1'b0, 2'b00, 32'h0, 1'b1, 32'h100);
        #1;
        push("mispredict", 32'd1);
        exp_look(1'b0, 2'b00, 32'h0, 32'h44);
        check_all("alloc");
        next_cycle();
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        exp_look(1'b1, 2'b10, 32'h100, 32'h100);
        exp_cnt(32'd1, 32'd1);
        check_all("alloc_after");

        // Collision: update 10 -> 11 while looking up the same PC
        set_upd(1'b1, 32'h40, 1'b1, 2'b10, 32'h100, 1'b1, 32'h100);
        #1;
        push("mispredict", 32'd0);
        exp_look(1'b1, 2'b10, 32'h100, 32'h100);
        check_all("collision");
        next_cycle();
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        exp_look(1'b1, 2'b11, 32'h100, 32'h100);
        exp_cnt(32'd2, 32'd1);
        check_all("collision_after");

        // Two more taken updates hold at 11
        for (int k = 0; k < 2; k++) begin
            set_upd(1'b1, 32'h40, 1'b1, 2'b11, 32'h100, 1'b1, 32'h100);
            #1;
            push("mispredict", 32'd0);
            check_all("sat_taken");
            next_cycle();
        end
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        exp_look(1'b1, 2'b11, 32'h100, 32'h100);
        exp_cnt(32'd4, 32'd1);
        check_all("sat_taken_after");

        // Four not-taken updates: 11->10->01->00->00; target untouched
        begin
            logic [1:0] h;
            logic [1:0] nh;
            int         mc;
            h  = 2'b11;
            mc = 1;
            for (int k = 0; k < 4; k++) begin
                nh = (h == 2'b00) ? 2'b00 : h - 2'b01;
                set_upd(1'b1, 32'h40, 1'b1, h, 32'h100, 1'b0, 32'h144);
                #1;
                push("mispredict", 32'(h[1]));
                check_all("sat_nt");
                if (h[1]) mc++;
                next_cycle();
                set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
                #1;
                exp_look(1'b1, nh, 32'h100, nh[1] ? 32'h100 : 32'h44);
                exp_cnt(32'(5 + k), 32'(mc));
                check_all("sat_nt_after");
                h = nh;
            end
        end

        // Alias: 0x60 shares index with 0x40
        bp.imemaddr_if = 32'h60;
        #1;
        exp_look(1'b0, 2'b00, 32'h0, 32'h64);
        check_all("alias_miss");
        next_cycle();
        set_upd(1'b1, 32'h60, 1'b0, 2'b00, 32'h0, 1'b0, 32'h80);
        #1;
        push("mispredict", 32'd0);
        check_all("alias_alloc");
        next_cycle();
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        #1;
        exp_look(1'b1, 2'b01, 32'h80, 32'h64);
        exp_cnt(32'd9, 32'd3);
        check_all("alias_hit");
        bp.imemaddr_if = 32'h40;
        #1;
        exp_look(1'b0, 2'b00, 32'h0, 32'h44);
        check_all("alias_evicted");

        // Target mismatch on a strongly-taken hit
        next_cycle();
        set_upd(1'b1, 32'h60, 1'b1, 2'b11, 32'h100, 1'b1, 32'h200);
        #1;
        push("mispredict", 32'd1);
        check_all("tgt_mismatch");
        next_cycle();
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        bp.imemaddr_if = 32'h60;
        #1;
        exp_look(1'b1, 2'b11, 32'h200, 32'h200);
        exp_cnt(32'd10, 32'd4);
        check_all("tgt_after");

        // update_en low: garbage MEM inputs ignored
        next_cycle();
        set_upd(1'b0, 32'h60, 1'b0, 2'b00, 32'h0, 1'b1, 32'h300);
        #1;
        push("mispredict", 32'd0);
        check_all("idle");
        next_cycle();
        #1;
        exp_look(1'b1, 2'b11, 32'h200, 32'h200);
        exp_cnt(32'd10, 32'd4);
        check_all("idle_after");

        // Reset asserted mid-cycle during an update: cleared immediately, update dropped
        set_upd(1'b1, 32'h40, 1'b0, 2'b00, 32'h0, 1'b1, 32'h500);
        #1;
        nrst = 1'b0;
        #1;
        exp_look(1'b0, 2'b00, 32'h0, 32'h64);
        exp_cnt(32'd0, 32'd0);
        check_all("async_reset");
        next_cycle();
        set_upd(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        nrst = 1'b1;
        bp.imemaddr_if = 32'h40;
        #1;
        exp_look(1'b0, 2'b00, 32'h0, 32'h44);
        exp_cnt(32'd0, 32'd0);
        check_all("reset_dropped_update");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
